// File: rtl/memtest_pkg.sv
// Shared types and constants for the DDR3 memory test engine.
package memtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WIPE,
        WRITE,
        VERIFY,
        DONE,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_WR,
        OUT_RD,
        OUT_REF
    } outstanding_t;

    localparam logic [1:0] MODE_ADDR = 2'b00;
    localparam logic [1:0] MODE_WALK = 2'b01;
    localparam logic [1:0] MODE_LFSR = 2'b10;
    localparam logic [1:0] MODE_ONES = 2'b11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [15:0] addr_pattern(input logic [31:0] a);
        return a[15:0] ^ {6'b0, a[25:16]} ^ 16'd59;
    endfunction

endpackage

// File: rtl/ddr3_refresh_sched.sv
// Refresh timer with one postponed-refresh credit; saturates at 2*REFRESH_CYCLES-2.
module ddr3_refresh_sched #(
    parameter int unsigned REFRESH_CYCLES = 615
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic refresh_executed,
    output logic refresh_needed
);

    localparam int unsigned   TW   = $clog2(2 * REFRESH_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(2 * REFRESH_CYCLES - 2);
    localparam logic [TW-1:0] TREF = TW'(REFRESH_CYCLES);

    logic [TW-1:0] timer_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else if (refresh_executed) begin
            timer_q <= timer_q - TREF;
        end else if (enable && timer_q != TMAX) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    assign refresh_needed = (timer_q >= TREF);

endmodule

// File: rtl/ddr3_memtest_engine.sv
// DDR3 bulk test engine: wipe, write and verify passes over a region via the controller user port.
// Define MEMTEST_LFSR_EN to build the 16-bit LFSR pattern for mode 10 (otherwise mode 10 = mode 00).
module ddr3_memtest_engine
    import memtest_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 26,
    parameter int unsigned           DATA_WIDTH     = 16,
    parameter int unsigned           START_ADDR     = 0,
    parameter int unsigned           TOTAL_SIZE     = 8*1024*1024,
    parameter int unsigned           REFRESH_CYCLES = 615,
    parameter logic [DATA_WIDTH-1:0] CMP_MASK       = DATA_WIDTH'(16'h00FF),
    parameter int unsigned           PASSES         = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic                  ctl_busy,
    input  logic                  ctl_data_ready,
    input  logic [DATA_WIDTH-1:0] ctl_dout,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic                  ctl_rd,
    output logic                  ctl_wr,
    output logic                  ctl_refresh,
    output logic [DATA_WIDTH-1:0] ctl_din,
    output logic                  running,
    output logic                  pass_ok,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic [15:0]           pass_count,
    output logic [23:0]           refresh_count
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(START_ADDR + TOTAL_SIZE - 1);

    state_t                  state_q, state_d;
    outstanding_t            out_q;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             addr32;
    logic [DATA_WIDTH-1:0]   walk, pattern, wr_data;
    logic [15:0]             pass_next;
    logic active, start_accept, refresh_needed;
    logic wr_done, rd_done, ref_done, word_done, last_word, mismatch, cmd_idle;
    logic cmd_free, issue_rd, issue_wr, issue_ref, verify_end;

    assign active       = (state_q == WIPE) || (state_q == WRITE) || (state_q == VERIFY);
    assign start_accept = start && !active;
    assign running      = active;

    // Pulse outputs are registered, so a completion is never taken in the pulse cycle itself
    assign wr_done   = (out_q == OUT_WR)  && !ctl_wr      && !ctl_busy;
    assign ref_done  = (out_q == OUT_REF) && !ctl_refresh && !ctl_busy;
    assign rd_done   = (out_q == OUT_RD)  && ctl_data_ready;
    assign word_done = wr_done || rd_done;
    assign last_word = (addr_q == LAST_ADDR);
    assign cmd_idle  = (out_q == OUT_NONE) || wr_done || rd_done || ref_done;
    assign mismatch  = rd_done && (|((ctl_dout ^ pattern) & CMP_MASK));

    assign cmd_free  = active && (out_q == OUT_NONE) && !ctl_busy && !stop;
    assign issue_ref = cmd_free && refresh_needed;
    assign issue_rd  = cmd_free && !refresh_needed && (state_q == VERIFY);
    assign issue_wr  = cmd_free && !refresh_needed && (state_q != VERIFY);

    assign pass_next  = pass_count + 16'd1;
    assign verify_end = (state_q == VERIFY) && word_done && last_word && !mismatch;

    assign addr32 = 32'(addr_q);
    assign walk   = DATA_WIDTH'(1) << (addr32 % DATA_WIDTH);

`ifdef MEMTEST_LFSR_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else if ((state_d == WRITE || state_d == VERIFY) && state_d != state_q) begin
            lfsr_q <= LFSR_SEED;
        end else if (word_done) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end
`endif

    always_comb begin
        case (mode_q)
            MODE_WALK: pattern = walk;
            MODE_ONES: pattern = '1;
`ifdef MEMTEST_LFSR_EN
            MODE_LFSR: pattern = DATA_WIDTH'(lfsr_q);
`endif
            default:   pattern = DATA_WIDTH'(addr_pattern(addr32));
        endcase
        wr_data = (state_q == WIPE) ? '0 : pattern;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) state_d = WIPE;
            end
            WIPE, WRITE, VERIFY: begin
                if (mismatch) begin
                    state_d = FAIL;
                end else if (word_done && last_word) begin
                    case (state_q)
                        WIPE:    state_d = WRITE;
                        WRITE:   state_d = VERIFY;
                        default: state_d = (PASSES == 0 || 32'(pass_next) < PASSES) ? WRITE : DONE;
                    endcase
                end else if (stop && cmd_idle) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q         <= OUT_NONE;
            mode_q        <= MODE_ADDR;
            addr_q        <= '0;
            ctl_addr      <= '0;
            ctl_rd        <= 1'b0;
            ctl_wr        <= 1'b0;
            ctl_refresh   <= 1'b0;
            ctl_din       <= '0;
            pass_ok       <= 1'b0;
            err_count     <= '0;
            fail_addr     <= '0;
            fail_exp      <= '0;
            fail_act      <= '0;
            pass_count    <= '0;
            refresh_count <= '0;
        end else begin
            ctl_rd      <= issue_rd;
            ctl_wr      <= issue_wr;
            ctl_refresh <= issue_ref;
            if (issue_rd || issue_wr) ctl_addr <= addr_q;
            if (issue_wr) ctl_din <= wr_data;

            if (issue_wr)      out_q <= OUT_WR;
            else if (issue_rd) out_q <= OUT_RD;
            else if (issue_ref) out_q <= OUT_REF;
            else if (wr_done || rd_done || ref_done) out_q <= OUT_NONE;

            if (start_accept) begin
                mode_q     <= mode;
                addr_q     <= FIRST_ADDR;
                pass_ok    <= 1'b0;
                err_count  <= '0;
                fail_addr  <= '0;
                fail_exp   <= '0;
                fail_act   <= '0;
                pass_count <= '0;
            end else if (word_done) begin
                addr_q <= last_word ? FIRST_ADDR : addr_q + ADDR_WIDTH'(1);
            end

            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
                if (err_count == '0) begin
                    fail_addr <= addr_q;
                    fail_exp  <= pattern;
                    fail_act  <= ctl_dout;
                end
            end

            if (verify_end) pass_count <= pass_next;
            if (state_d == DONE && state_q != DONE) pass_ok <= (err_count == '0);
            if (issue_ref) refresh_count <= refresh_count + 24'd1;
        end
    end

    ddr3_refresh_sched #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_sched (
        .clk             (clk),
        .resetn          (resetn),
        .enable          (state_q != IDLE),
        .refresh_executed(issue_ref),
        .refresh_needed  (refresh_needed)
    );

endmodule

// File: tb/tb_ddr3_memtest_engine.sv
// Bench for ddr3_memtest_engine: two instances (PASSES=1 and PASSES=0) each on a behavioural controller.
module tb_ddr3_memtest_engine;

    localparam int AW = 26;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          start [2];
    logic          stop [2];
    logic [1:0]    mode [2];
    logic          ctl_busy [2];
    logic          ctl_data_ready [2];
    logic [DW-1:0] ctl_dout [2];
    logic [AW-1:0] ctl_addr [2];
    logic          ctl_rd [2];
    logic          ctl_wr [2];
    logic          ctl_refresh [2];
    logic [DW-1:0] ctl_din [2];
    logic          running [2];
    logic          pass_ok [2];
    logic [15:0]   err_count [2];
    logic [AW-1:0] fail_addr [2];
    logic [DW-1:0] fail_exp [2];
    logic [DW-1:0] fail_act [2];
    logic [15:0]   pass_count [2];
    logic [23:0]   refresh_count [2];

    ddr3_memtest_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .TOTAL_SIZE(64),
        .REFRESH_CYCLES(40), .CMP_MASK(16'h00FF), .PASSES(0)
    ) dut_loop (
        .clk(clk), .resetn(resetn), .start(start[0]), .stop(stop[0]), .mode(mode[0]),
        .ctl_busy(ctl_busy[0]), .ctl_data_ready(ctl_data_ready[0]), .ctl_dout(ctl_dout[0]),
        .ctl_addr(ctl_addr[0]), .ctl_rd(ctl_rd[0]), .ctl_wr(ctl_wr[0]), .ctl_refresh(ctl_refresh[0]),
        .ctl_din(ctl_din[0]), .running(running[0]), .pass_ok(pass_ok[0]), .err_count(err_count[0]),
        .fail_addr(fail_addr[0]), .fail_exp(fail_exp[0]), .fail_act(fail_act[0]),
        .pass_count(pass_count[0]), .refresh_count(refresh_count[0])
    );

    ddr3_memtest_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(0), .TOTAL_SIZE(64),
        .REFRESH_CYCLES(40), .CMP_MASK(16'h00FF), .PASSES(1)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start[1]), .stop(stop[1]), .mode(mode[1]),
        .ctl_busy(ctl_busy[1]), .ctl_data_ready(ctl_data_ready[1]), .ctl_dout(ctl_dout[1]),
        .ctl_addr(ctl_addr[1]), .ctl_rd(ctl_rd[1]), .ctl_wr(ctl_wr[1]), .ctl_refresh(ctl_refresh[1]),
        .ctl_din(ctl_din[1]), .running(running[1]), .pass_ok(pass_ok[1]), .err_count(err_count[1]),
        .fail_addr(fail_addr[1]), .fail_exp(fail_exp[1]), .fail_act(fail_act[1]),
        .pass_count(pass_count[1]), .refresh_count(refresh_count[1])
    );

    // Controller model: busy 4 cycles per command, read data 6 cycles after rd
    logic [DW-1:0] mem [2][64];
    int unsigned   busy_cnt [2];
    int unsigned   rd_lat [2];
    logic [5:0]    rd_addr [2];
    logic [5:0]    last_addr [2];
    int unsigned   wr_cnt [2];
    int unsigned   rd_cnt [2];
    int unsigned   ref_cnt [2];
    logic          seq_err [2];
    logic          wipe_nz [2];
    logic [DW-1:0] din_log [2][4];
    logic          hold [2];
    logic          clr_stats;
    logic          corrupt_en;
    logic [5:0]    corrupt_addr;
    logic [DW-1:0] corrupt_bits;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (clr_stats) begin
                busy_cnt[i] <= 0; rd_lat[i] <= 0; last_addr[i] <= 6'd63;
                wr_cnt[i] <= 0; rd_cnt[i] <= 0; ref_cnt[i] <= 0;
                seq_err[i] <= 1'b0; wipe_nz[i] <= 1'b0;
            end else begin
                if (ctl_wr[i] || ctl_rd[i]) begin
                    if (ctl_addr[i][5:0] != last_addr[i] + 6'd1 || |ctl_addr[i][AW-1:6])
                        seq_err[i] <= 1'b1;
                    last_addr[i] <= ctl_addr[i][5:0];
                end
                if (ctl_wr[i]) begin
                    mem[i][ctl_addr[i][5:0]] <= ctl_din[i];
                    wr_cnt[i] <= wr_cnt[i] + 1;
                    if (wr_cnt[i] < 64 && ctl_din[i] != '0) wipe_nz[i] <= 1'b1;
                    if (wr_cnt[i] >= 64 && wr_cnt[i] < 128) begin
                        case (ctl_addr[i][5:0])
                            6'd0:  din_log[i][0] <= ctl_din[i];
                            6'd1:  din_log[i][1] <= ctl_din[i];
                            6'd2:  din_log[i][2] <= ctl_din[i];
                            6'd17: din_log[i][3] <= ctl_din[i];
                            default: ;
                        endcase
                    end
                end
                if (ctl_rd[i]) begin
                    rd_cnt[i]  <= rd_cnt[i] + 1;
                    rd_addr[i] <= ctl_addr[i][5:0];
                    rd_lat[i]  <= 6;
                end else if (rd_lat[i] != 0) begin
                    rd_lat[i] <= rd_lat[i] - 1;
                end
                if (ctl_refresh[i]) ref_cnt[i] <= ref_cnt[i] + 1;
                if (ctl_wr[i] || ctl_rd[i] || ctl_refresh[i]) busy_cnt[i] <= 4;
                else if (busy_cnt[i] != 0) busy_cnt[i] <= busy_cnt[i] - 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ctl_busy[i]       = hold[i] || (busy_cnt[i] != 0);
            ctl_data_ready[i] = (rd_lat[i] == 1);
            ctl_dout[i]       = mem[i][rd_addr[i]] ^
                                ((corrupt_en && rd_addr[i] == corrupt_addr) ? corrupt_bits : '0);
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic begin_run(input int i, input logic [1:0] m);
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
        mode[i] = m; start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string tag);
        int n = 0;
        while (running[i] && n < 8000) begin @(negedge clk); n++; end
        check_eq({tag, "_finished"}, 32'(running[i]), 0);
    endtask

    task automatic wait_writes(input int i, input int unsigned target, input string tag);
        int n = 0;
        while (wr_cnt[i] < target && n < 8000) begin @(negedge clk); n++; end
        check_eq({tag, "_reached"}, 32'(wr_cnt[i] >= target), 1);
    endtask

    task automatic check_din(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2, input logic [DW-1:0] e17);
        check_eq({tag, "_din0"}, 32'(din_log[1][0]), 32'(e0));
        check_eq({tag, "_din1"}, 32'(din_log[1][1]), 32'(e1));
        check_eq({tag, "_din2"}, 32'(din_log[1][2]), 32'(e2));
        check_eq({tag, "_din17"}, 32'(din_log[1][3]), 32'(e17));
    endtask

    initial begin
        int n, kind, refs, total;
        resetn = 1'b0; clr_stats = 1'b1; corrupt_en = 1'b0; corrupt_addr = '0; corrupt_bits = '0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; stop[i] = 1'b0; mode[i] = 2'b00; hold[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_running", 32'(running[1]), 0);
        check_eq("rst_pass_ok", 32'(pass_ok[1]), 0);
        check_eq("rst_err", 32'(err_count[1]), 0);
        check_eq("rst_pass_cnt", 32'(pass_count[1]), 0);
        check_eq("rst_ref_cnt", 32'(refresh_count[1]), 0);
        check_eq("rst_addr", 32'(ctl_addr[1]), 0);
        resetn = 1'b1; clr_stats = 1'b0;

        // Plain mode 00 run with a stray start mid-run that must be ignored
        begin_run(1, 2'b00);
        wait_writes(1, 100, "a_mid");
        start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
        wait_idle(1, "a");
        check_eq("a_pass_ok", 32'(pass_ok[1]), 1);
        check_eq("a_err", 32'(err_count[1]), 0);
        check_eq("a_pass_cnt", 32'(pass_count[1]), 1);
        check_eq("a_wr_cnt", wr_cnt[1], 128);
        check_eq("a_rd_cnt", rd_cnt[1], 64);
        check_eq("a_seq_err", 32'(seq_err[1]), 0);
        check_eq("a_wipe_zero", 32'(wipe_nz[1]), 0);
        check_eq("a_refreshed", 32'(refresh_count[1] != 0), 1);
        check_din("a", 16'h003B, 16'h003A, 16'h0039, 16'h002A);

        // Compared bit corrupted at word 17
        corrupt_en = 1'b1; corrupt_addr = 6'd17; corrupt_bits = 16'h0004;
        begin_run(1, 2'b00);
        wait_idle(1, "b");
        check_eq("b_pass_ok", 32'(pass_ok[1]), 0);
        check_eq("b_err", 32'(err_count[1]), 1);
        check_eq("b_fail_addr", 32'(fail_addr[1]), 17);
        check_eq("b_fail_exp", 32'(fail_exp[1]), 32'h2A);
        check_eq("b_fail_act", 32'(fail_act[1]), 32'h2E);
        check_eq("b_rd_cnt", rd_cnt[1], 18);

        // Masked bit corrupted: ignored
        corrupt_bits = 16'h1000;
        begin_run(1, 2'b00);
        wait_idle(1, "c");
        check_eq("c_pass_ok", 32'(pass_ok[1]), 1);
        check_eq("c_err", 32'(err_count[1]), 0);
        check_eq("c_fail_addr", 32'(fail_addr[1]), 0);
        corrupt_en = 1'b0;

        // Long busy: owed refreshes (at most two) go out before the next rd/wr
        begin_run(1, 2'b00);
        wait_writes(1, 80, "d_mid");
        hold[1] = 1'b1;
        repeat (150) @(negedge clk);
        hold[1] = 1'b0;
        kind = 0; refs = 0; n = 0;
        while (kind < 2 && n < 200) begin
            @(negedge clk); n++;
            if (ctl_refresh[1]) begin refs++; if (kind == 0) kind = 1; end
            if (ctl_wr[1] || ctl_rd[1]) kind = (kind == 0) ? 3 : 2;
        end
        check_eq("d_refresh_first", kind, 2);
        check_eq("d_refresh_burst", refs, 2);
        wait_idle(1, "d");
        check_eq("d_pass_ok", 32'(pass_ok[1]), 1);
        check_eq("d_wr_cnt", wr_cnt[1], 128);
        check_eq("d_rd_cnt", rd_cnt[1], 64);
        check_eq("d_seq_err", 32'(seq_err[1]), 0);

        begin_run(1, 2'b01);
        wait_idle(1, "walk");
        check_eq("walk_pass_ok", 32'(pass_ok[1]), 1);
        check_din("walk", 16'h0001, 16'h0002, 16'h0004, 16'h0002);

        begin_run(1, 2'b11);
        wait_idle(1, "ones");
        check_eq("ones_pass_ok", 32'(pass_ok[1]), 1);
        check_din("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        begin_run(1, 2'b10);
        wait_idle(1, "m10");
        check_eq("m10_pass_ok", 32'(pass_ok[1]), 1);
`ifdef MEMTEST_LFSR_EN
        check_eq("m10_din0", 32'(din_log[1][0]), 32'hACE1);
        check_eq("m10_din1", 32'(din_log[1][1]), 32'h5670);
        check_eq("m10_din2", 32'(din_log[1][2]), 32'hAB38);
`else
        check_din("m10", 16'h003B, 16'h003A, 16'h0039, 16'h002A);
`endif

        // PASSES=0 instance: stop during the second verify pass at word 30
        begin_run(0, 2'b00);
        n = 0;
        while (!(ctl_rd[0] && ctl_addr[0] == 30 && rd_cnt[0] >= 64) && n < 8000) begin
            @(negedge clk); n++;
        end
        check_eq("s_reached", 32'(ctl_rd[0] && ctl_addr[0] == 30), 1);
        stop[0] = 1'b1;
        wait_idle(0, "s");
        stop[0] = 1'b0;
        check_eq("s_pass_ok", 32'(pass_ok[0]), 1);
        check_eq("s_pass_cnt", 32'(pass_count[0]), 1);
        check_eq("s_rd_cnt", rd_cnt[0], 95);
        check_eq("s_wr_cnt", wr_cnt[0], 192);
        check_eq("s_seq_err", 32'(seq_err[0]), 0);

        // Reset in the middle of a burst
        begin_run(1, 2'b00);
        wait_writes(1, 20, "r_mid");
        resetn = 1'b0;
        #1;
        check_eq("r_running", 32'(running[1]), 0);
        check_eq("r_wr", 32'(ctl_wr[1]), 0);
        check_eq("r_addr", 32'(ctl_addr[1]), 0);
        check_eq("r_din", 32'(ctl_din[1]), 0);
        check_eq("r_ref_cnt", 32'(refresh_count[1]), 0);
        total = wr_cnt[1] + rd_cnt[1] + ref_cnt[1];
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("r_no_cmds", wr_cnt[1] + rd_cnt[1] + ref_cnt[1], total);
        check_eq("r_idle", 32'(running[1]), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
